// File: rtl/usr_pkg.sv
// Shared definitions for the command-driven universal shift register.
//  - USR_* : 3-bit command mode encodings carried on cmd_mode
//  - state_t : command FSM states
//  - is_shift_mode() : true for modes that take cmd_count steps
package usr_pkg;

  localparam logic [2:0] USR_HOLD  = 3'd0;
  localparam logic [2:0] USR_SHR   = 3'd1;
  localparam logic [2:0] USR_SHL   = 3'd2;
  localparam logic [2:0] USR_LOAD  = 3'd3;
  localparam logic [2:0] USR_ROTR  = 3'd4;
  localparam logic [2:0] USR_ROTL  = 3'd5;
  localparam logic [2:0] USR_ASR   = 3'd6;
  localparam logic [2:0] USR_CLEAR = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic is_shift_mode(input logic [2:0] mode);
    return (mode == USR_SHR)  || (mode == USR_SHL) || (mode == USR_ROTR) ||
           (mode == USR_ROTL) || (mode == USR_ASR);
  endfunction

endpackage

// File: rtl/usr_step_unit.sv
// Combinational single-step datapath of the shift register.
//  mode      in  3      command mode (USR_*)
//  q         in  WIDTH  current register contents
//  sin_l     in  1      serial in to LSB (SHL only)
//  sin_r     in  1      serial in to MSB (SHR only)
//  q_next    out WIDTH  contents after one step
//  sout_next out 1      bit leaving the register on this step
// Outputs are meaningful only for the shift/rotate modes; for the other modes
// q passes through and sout_next is 0 (the top never uses it then).
module usr_step_unit
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] q,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q_next,
  output logic             sout_next
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    q_next    = q;
    sout_next = 1'b0;
    case (mode)
      USR_SHR: begin
        q_next    = {sin_r, q[WIDTH-1:1]};
        sout_next = q[0];
      end
      USR_SHL: begin
        q_next    = {q[WIDTH-2:0], sin_l};
        sout_next = q[WIDTH-1];
      end
      USR_ROTR: begin
        q_next    = {q[0], q[WIDTH-1:1]};
        sout_next = q[0];
      end
      USR_ROTL: begin
        q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
        sout_next = q[WIDTH-1];
      end
      USR_ASR: begin
        q_next    = {q[WIDTH-1], q[WIDTH-1:1]};
        sout_next = q[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/usr_cmd_shifter.sv
// Universal shift register driven by a valid/ready command handshake.
//  clk        in  1      clock, rising edge
//  rst        in  1      asynchronous reset, active low
//  cmd_valid  in  1      command present
//  cmd_ready  out 1      block idle, command will be accepted
//  cmd_mode   in  3      USR_* mode
//  cmd_count  in  CNT_W  number of steps (shift/rotate modes)
//  load_data  in  WIDTH  parallel data for LOAD, captured on acceptance
//  en         in  1      step enable; 0 stalls a running shift command
//  sin_r      in  1      serial in to MSB on SHR
//  sin_l      in  1      serial in to LSB on SHL
//  q          out WIDTH  register contents
//  sout       out 1      last bit shifted/rotated out
//  busy       out 1      command in progress
//  done       out 1      one-cycle completion pulse
// A command is captured in IDLE and executed in RUN. Non-shift commands and
// zero-count shifts spend exactly one cycle in RUN; shift commands spend one
// enabled cycle per step. Completion writes done, so done is high in the
// first IDLE cycle and a new command may be accepted in that same cycle.
module usr_cmd_shifter
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] load_data,
  input  logic             en,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_t           state, state_next;
  logic [2:0]       mode_r, mode_next;
  logic [CNT_W-1:0] remaining, remaining_next;
  logic [WIDTH-1:0] load_r, load_next;
  logic [WIDTH-1:0] q_next, q_step;
  logic             sout_next, sout_step;
  logic             done_next;
  logic             single_cycle;

  usr_step_unit #(.WIDTH(WIDTH)) u_step (
    .mode      (mode_r),
    .q         (q),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .q_next    (q_step),
    .sout_next (sout_step)
  );

  // A shift command only reaches RUN with remaining==0 when cmd_count was 0;
  // a running shift leaves RUN on the step that takes remaining from 1 to 0.
  assign single_cycle = !is_shift_mode(mode_r) || (remaining == '0);

  always_comb begin
    state_next     = state;
    mode_next      = mode_r;
    remaining_next = remaining;
    load_next      = load_r;
    q_next         = q;
    sout_next      = sout;
    done_next      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_next     = RUN;
          mode_next      = cmd_mode;
          remaining_next = cmd_count;
          load_next      = load_data;
        end
      end
      RUN: begin
        if (single_cycle) begin
          if (mode_r == USR_LOAD)  q_next = load_r;
          if (mode_r == USR_CLEAR) q_next = '0;
          done_next  = 1'b1;
          state_next = IDLE;
        end else if (en) begin
          q_next         = q_step;
          sout_next      = sout_step;
          remaining_next = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mode_r    <= USR_HOLD;
      remaining <= '0;
      load_r    <= '0;
      q         <= '0;
      sout      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      mode_r    <= mode_next;
      remaining <= remaining_next;
      load_r    <= load_next;
      q         <= q_next;
      sout      <= sout_next;
      done      <= done_next;
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RUN);

endmodule

// File: tb/tb_usr_cmd_shifter.sv
// Directed bench for usr_cmd_shifter (WIDTH=8, CNT_W=4). Inputs change and
// outputs are sampled 1ns after each rising edge.
module tb_usr_cmd_shifter;
  import usr_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_mode = USR_HOLD;
  logic [3:0] cmd_count = '0;
  logic [7:0] load_data = '0;
  logic       en = 1'b1;
  logic       sin_r = 1'b0;
  logic       sin_l = 1'b0;
  logic [7:0] q;
  logic       sout;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  usr_cmd_shifter #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_count (cmd_count),
    .load_data (load_data),
    .en        (en),
    .sin_r     (sin_r),
    .sin_l     (sin_l),
    .q         (q),
    .sout      (sout),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command, waits (bounded) for cmd_ready, and returns 1ns after
  // the acceptance edge. With keep=1 cmd_valid stays asserted afterwards.
  task automatic issue(input logic [2:0] m, input logic [3:0] c,
                       input logic [7:0] d, input bit keep);
    int t = 0;
    cmd_mode  = m;
    cmd_count = c;
    load_data = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && t < 20) begin
      tick();
      t++;
    end
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL issue_ready mode=%0d: cmd_ready=%b, required 1", m, cmd_ready);
    end
    tick();
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_vec++;
    if ({q, sout, busy, done, cmd_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: q=%h sout=%b busy=%b done=%b ready=%b, required 00 0 0 0 1",
               q, sout, busy, done, cmd_ready);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] exp_q [3] = '{8'h01, 8'h03, 8'h07};
    sin_l = 1'b1;
    issue(USR_SHL, 4'd10, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({q, sout, busy, done} !== {exp_q[i], 1'b0, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL shl_step%0d: q=%h sout=%b busy=%b done=%b, required %h 0 1 0",
                 i + 1, q, sout, busy, done, exp_q[i]);
      end
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if ({q, sout, busy, done, cmd_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_mid_run: q=%h sout=%b busy=%b done=%b ready=%b, required 00 0 0 0 1",
               q, sout, busy, done, cmd_ready);
    end
    tick();
    rst = 1'b1;
    sin_l = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({q, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL reset_no_done%0d: q=%h busy=%b done=%b, required 00 0 0",
                 i, q, busy, done);
      end
    end
  endtask

  task automatic test_load();
    issue(USR_LOAD, 4'd0, 8'hA5, 1'b0);
    n_vec++;
    if ({q, busy, done} !== {8'h00, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL load_e0: q=%h busy=%b done=%b, required 00 1 0", q, busy, done);
    end
    tick();
    n_vec++;
    if ({q, busy, done, cmd_ready} !== {8'hA5, 1'b0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL load_e1: q=%h busy=%b done=%b ready=%b, required a5 0 1 1",
               q, busy, done, cmd_ready);
    end
    tick();
    n_vec++;
    if ({q, busy, done} !== {8'hA5, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL load_e2: q=%h busy=%b done=%b, required a5 0 0", q, busy, done);
    end
  endtask

  task automatic test_shr();
    logic [7:0] exp_q [3] = '{8'hD2, 8'hE9, 8'hF4};
    logic       exp_s [3] = '{1'b1, 1'b0, 1'b1};
    sin_r = 1'b1;
    issue(USR_SHR, 4'd3, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({q, sout, busy, done} !== {exp_q[i], exp_s[i], (i != 2), (i == 2)}) begin
        n_err++;
        $display("FAIL shr_step%0d: q=%h sout=%b busy=%b done=%b, required %h %b %b %b",
                 i + 1, q, sout, busy, done, exp_q[i], exp_s[i], (i != 2), (i == 2));
      end
    end
    sin_r = 1'b0;
    tick();
    n_vec++;
    if ({q, sout, done} !== {8'hF4, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL shr_after: q=%h sout=%b done=%b, required f4 1 0", q, sout, done);
    end
  endtask

  task automatic test_rotl();
    logic [7:0] exp_q;
    logic       exp_s;
    issue(USR_LOAD, 4'd0, 8'h81, 1'b0);
    tick();
    issue(USR_ROTL, 4'd9, 8'h00, 1'b0);
    exp_q = 8'h81;
    for (int i = 1; i <= 9; i++) begin
      sin_l = ~sin_l;
      exp_s = exp_q[7];
      exp_q = {exp_q[6:0], exp_q[7]};
      tick();
      n_vec++;
      if ({q, sout, busy, done} !== {exp_q, exp_s, (i != 9), (i == 9)}) begin
        n_err++;
        $display("FAIL rotl_step%0d: q=%h sout=%b busy=%b done=%b, required %h %b %b %b",
                 i, q, sout, busy, done, exp_q, exp_s, (i != 9), (i == 9));
      end
    end
    n_vec++;
    if (q !== 8'h03) begin
      n_err++;
      $display("FAIL rotl_final: q=%h, required 03", q);
    end
    sin_l = 1'b0;
  endtask

  task automatic test_asr_stall();
    issue(USR_LOAD, 4'd0, 8'h90, 1'b0);
    tick();
    n_vec++;
    if ({q, sout, busy, done} !== {8'h90, 1'b1, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL asr_load: q=%h sout=%b busy=%b done=%b, required 90 1 0 1",
               q, sout, busy, done);
    end
    issue(USR_ASR, 4'd2, 8'h00, 1'b0);
    tick();
    n_vec++;
    if ({q, sout, busy, done} !== {8'hC8, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL asr_step1: q=%h sout=%b busy=%b done=%b, required c8 0 1 0",
               q, sout, busy, done);
    end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if ({q, sout, busy, done} !== {8'hC8, 1'b0, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL asr_stall%0d: q=%h sout=%b busy=%b done=%b, required c8 0 1 0",
                 i, q, sout, busy, done);
      end
    end
    en = 1'b1;
    tick();
    n_vec++;
    if ({q, sout, busy, done} !== {8'hE4, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL asr_step2: q=%h sout=%b busy=%b done=%b, required e4 0 0 1",
               q, sout, busy, done);
    end
  endtask

  task automatic test_back_to_back();
    // SHR N=0, then a LOAD held on cmd_valid: ignored while busy, taken on done cycle.
    issue(USR_SHR, 4'd0, 8'h00, 1'b1);
    cmd_mode  = USR_LOAD;
    load_data = 8'h3C;
    tick();
    n_vec++;
    if ({q, sout, busy, done, cmd_ready} !== {8'hE4, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL shr0_e1: q=%h sout=%b busy=%b done=%b ready=%b, required e4 0 0 1 1",
               q, sout, busy, done, cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    n_vec++;
    if ({q, busy, done} !== {8'hE4, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_accept: q=%h busy=%b done=%b, required e4 1 0", q, busy, done);
    end
    tick();
    n_vec++;
    if ({q, busy, done} !== {8'h3C, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL b2b_load: q=%h busy=%b done=%b, required 3c 0 1", q, busy, done);
    end
    // ROTR N=2 with a CLEAR held during the whole run.
    issue(USR_ROTR, 4'd2, 8'h00, 1'b1);
    cmd_mode = USR_CLEAR;
    tick();
    n_vec++;
    if ({q, sout, busy, done} !== {8'h1E, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL rotr_step1: q=%h sout=%b busy=%b done=%b, required 1e 0 1 0",
               q, sout, busy, done);
    end
    tick();
    n_vec++;
    if ({q, sout, busy, done} !== {8'h0F, 1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL rotr_step2: q=%h sout=%b busy=%b done=%b, required 0f 0 0 1",
               q, sout, busy, done);
    end
    tick();
    cmd_valid = 1'b0;
    n_vec++;
    if ({q, busy, done} !== {8'h0F, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL clear_accept: q=%h busy=%b done=%b, required 0f 1 0", q, busy, done);
    end
    tick();
    n_vec++;
    if ({q, busy, done} !== {8'h00, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL clear_e1: q=%h busy=%b done=%b, required 00 0 1", q, busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_load();
    test_shr();
    test_rotl();
    test_asr_stall();
    test_back_to_back();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
